// File: rtl/seven_seg_reader.sv
// seven_seg_reader
// Passive observer of a multiplexed, active-low seven-segment display bus.
// It recovers the hex nibble shown on each digit, which is the inverse of
// the 0-F segment encoding. The bus is filtered for stability first, and a
// one-cycle frame strobe is raised once every digit has been read back.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   sevenBit     segment pattern, active-low, bit0 = a ... bit6 = g
//   digitSel     anode select, active-low one-hot; all ones = blanked
//   value        decoded nibbles, digit i in value[4i+3:4i]
//   digitValid   bit i set when nibble i holds a legal decode
//   frameValid   one-cycle pulse once all digits have been read since the last pulse
//   patternError one-cycle pulse on an accepted illegal pattern or select
module seven_seg_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          sevenBit,
    input  logic [DIGITS-1:0]   digitSel,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   digitValid,
    output logic                frameValid,
    output logic                patternError
);

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned SAMPLE_W = DIGITS + SEG_W;
    localparam int unsigned VALUE_W  = NIB_W * DIGITS;
    localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] ALL_DIGITS = '1;

    // Inverse segment table: returns {legal, nibble}; unknown patterns are illegal.
    function automatic logic [NIB_W:0] decodeSeg(input logic [SEG_W-1:0] seg);
        logic [NIB_W:0] res;
        res = '0;
        unique case (seg)
            7'b1000000: res = {1'b1, 4'h0};
            7'b1111001: res = {1'b1, 4'h1};
            7'b0100100: res = {1'b1, 4'h2};
            7'b0110000: res = {1'b1, 4'h3};
            7'b0011001: res = {1'b1, 4'h4};
            7'b0010010: res = {1'b1, 4'h5};
            7'b0000010: res = {1'b1, 4'h6};
            7'b1111000: res = {1'b1, 4'h7};
            7'b0000000: res = {1'b1, 4'h8};
            7'b0011000: res = {1'b1, 4'h9};
            7'b0001000: res = {1'b1, 4'hA};
            7'b0000011: res = {1'b1, 4'hB};
            7'b0100111: res = {1'b1, 4'hC};
            7'b0100001: res = {1'b1, 4'hD};
            7'b0000110: res = {1'b1, 4'hE};
            7'b0001110: res = {1'b1, 4'hF};
            default:    res = '0;
        endcase
        return res;
    endfunction

    // Registered state
    logic [SAMPLE_W-1:0] sampleReg;
    logic [CNT_W-1:0]    stableCnt;
    logic                accepted;
    logic [DIGITS-1:0]   seen;

    // Next-state values
    logic [CNT_W-1:0]    stableCntNext;
    logic                acceptedNext;
    logic [DIGITS-1:0]   seenNext;
    logic [VALUE_W-1:0]  valueNext;
    logic [DIGITS-1:0]   digitValidNext;
    logic                frameValidNext;
    logic                patternErrorNext;

    // Combinational helpers
    logic [SAMPLE_W-1:0] sampleIn;
    logic                sampleSame;
    logic                acceptC;
    logic [DIGITS-1:0]   selLow;
    logic                selOneHot;
    logic [NIB_W:0]      decoded;
    logic [VALUE_W-1:0]  nibMask;

    assign sampleIn   = {digitSel, sevenBit};
    assign sampleSame = (sampleIn == sampleReg);
    assign selLow     = ~sampleReg[SAMPLE_W-1:SEG_W];
    // Non-zero one-hot test; the all-zero (blank) case is handled separately.
    assign selOneHot  = ((selLow & (selLow - DIGITS'(1))) == '0);
    assign decoded    = decodeSeg(sampleReg[SEG_W-1:0]);

    // Nibble lane mask for the selected digit (shift form keeps indices in range)
    always_comb begin
        nibMask = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (((selLow >> i) & DIGITS'(1)) != '0) begin
                nibMask = nibMask | (VALUE_W'(4'hF) << (NIB_W * i));
            end
        end
    end

    // Stability filter, accept decision, decode and frame tracking
    always_comb begin
        stableCntNext    = stableCnt;
        acceptedNext     = accepted;
        seenNext         = seen;
        valueNext        = value;
        digitValidNext   = digitValid;
        frameValidNext   = 1'b0;
        patternErrorNext = 1'b0;
        acceptC          = 1'b0;

        if (!sampleSame) begin
            stableCntNext = '0;
            acceptedNext  = 1'b0;
        end else begin
            if (stableCnt != CNT_MAX) begin
                stableCntNext = stableCnt + CNT_W'(1);
            end
            // Fire on the edge where the count reaches the threshold, once per pattern.
            acceptC = !accepted && (stableCntNext == CNT_MAX);
            if (acceptC) begin
                acceptedNext = 1'b1;
            end
        end

        if (acceptC) begin
            if (selLow == '0) begin
                // Blanked bus: nothing to read
            end else if (!selOneHot) begin
                patternErrorNext = 1'b1;
            end else if (decoded[NIB_W]) begin
                valueNext      = (value & ~nibMask) | ({DIGITS{decoded[NIB_W-1:0]}} & nibMask);
                digitValidNext = digitValid | selLow;
                seenNext       = seen | selLow;
            end else begin
                digitValidNext   = digitValid & ~selLow;
                patternErrorNext = 1'b1;
            end
        end

        // Completed frame: strobe and restart the mask on the same edge
        if (seenNext == ALL_DIGITS) begin
            frameValidNext = 1'b1;
            seenNext       = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleReg    <= '1;
            stableCnt    <= '0;
            accepted     <= 1'b0;
            seen         <= '0;
            value        <= '0;
            digitValid   <= '0;
            frameValid   <= 1'b0;
            patternError <= 1'b0;
        end else begin
            sampleReg    <= sampleIn;
            stableCnt    <= stableCntNext;
            accepted     <= acceptedNext;
            seen         <= seenNext;
            value        <= valueNext;
            digitValid   <= digitValidNext;
            frameValid   <= frameValidNext;
            patternError <= patternErrorNext;
        end
    end

endmodule

// File: doc/seven_seg_reader.md
# seven_seg_reader

Monitors a multiplexed, active-low seven-segment display bus and recovers the hexadecimal nibble shown on each digit. It performs the inverse of the team's 0-F segment encoding. It sits on the display output path in simulation and on-board self-test, so that displayed values can be checked against the processor state that produced them. Inputs are filtered for stability before decoding, and a frame strobe is raised once every digit has been read back.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1-8)
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (>= 1)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- sevenBit  input  7  segment pattern, active-low; bit0 = a … bit6 = g
- digitSel  input  DIGITS  anode select, active-low one-hot; all ones = blanked
- value  output  4*DIGITS  decoded nibbles; digit i in value[4i+3:4i]
- digitValid  output  DIGITS  bit i set = nibble i holds a legal decode
- frameValid  output  1  one-cycle pulse; all digits read back since the last pulse
- patternError  output  1  one-cycle pulse on an accepted illegal pattern or illegal select

## Operation
- Input stage: {digitSel, sevenBit} registered every cycle. Reset value is all ones (blank).
- Stability counter:
  - Cleared whenever the new sample differs from the previous sample.
  - Increments on each equal sample and saturates at STABLE_CYCLES.
  - Width is clog2(STABLE_CYCLES+1).
- Accept: fires once when the counter reaches STABLE_CYCLES. An `accepted` flag blocks re-accept until the sample changes.
- Accept handling:
  - digitSel all ones: ignored. No output change, no error.
  - digitSel with more than one bit low: patternError pulse. value and digitValid unchanged.
  - Exactly one bit i low: sevenBit is decoded through the inverse table below.
- Inverse table (sevenBit -> nibble):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0011000->9, 0001000->A, 0000011->b
  - 0100111->c, 0100001->d, 0000110->E, 0001110->F
- Legal decode on digit i: nibble i is written, digitValid[i] is set, seen[i] is set.
- Illegal decode on digit i: patternError pulses, digitValid[i] is cleared, nibble i keeps its old value, seen[i] is unchanged.
- Frame logic:
  - Internal seen mask of DIGITS bits.
  - When the mask becomes all ones, frameValid pulses on that same edge and the mask clears.
  - Re-reading a digit before the frame completes is allowed. Its nibble is overwritten; the mask is unchanged.
- Only one accept can occur per cycle, so at most one digit updates per cycle.

## Timing
- Reset (asynchronous, active-high) clears the following immediately:
  - outputs: value = 0, digitValid = 0, frameValid = 0, patternError = 0
  - internal state: counter = 0, seen = 0, accepted = 0
  - input register: all ones
- Latency:
  - Let edge k be the first edge that samples a new input.
  - The accept, and every resulting output change, occurs on edge k+STABLE_CYCLES.
  - With STABLE_CYCLES = 1, outputs change on edge k+1.
- Glitch rejection: an input held for fewer than STABLE_CYCLES+1 sampling edges produces no output change.
- Output pulses: frameValid and patternError are registered and high for exactly one cycle.
- A pattern held indefinitely produces exactly one accept.
- Reset mid-frame: the partial frame is discarded, and no frameValid is emitted for it after release.
- No handshake or back-pressure; the reader is a passive observer.

## Test plan
- Reset check: assert rst asynchronously between clock edges -> all outputs 0 immediately; they remain 0 with the bus held at blank.
- Single digit: digitSel=1110, sevenBit=0100100 held 10 cycles -> on edge k+4, value[3:0]=2 and digitValid=0001. No frameValid. No second accept.
- Glitch rejection: on digit 0, 1111000 held 3 edges, then 1000000 held 8 edges -> value[3:0] never equals 7 and ends at 0.
- Full frame: scan digits 0-3 with patterns for 1, A, b, F, each held 8 cycles -> value=16'hFBA1, digitValid=1111, frameValid high for exactly one cycle on the 4th accept. Repeating the scan gives a second single pulse.
- Errors:
  - 1111111 on digit 1 after a legal 5 -> one-cycle patternError pulse, digitValid[1]=0, value[7:4]=5.
  - digitSel=1100 -> patternError pulse, no value change.
  - Blank bus -> no error.
- Reset mid-operation: accept digits 0-2, pulse rst, then accept only digit 3 -> no frameValid pulse, digitValid=1000.
